unified_mem_arbiter: RTL and testbench

//  Shares the single-ported unified instruction/data memory (8-bit word address, 32-bit words)

---
 rtl/unified_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Two-port arbiter for the single-ported unified instruction/data memory: fetch vs load/store.
// Define UMA_TEXT_PROT_EN to suppress stores below TEXT_LIMIT (reported through d_err).
module unified_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MEM_DEPTH    = 128,
  parameter int unsigned TEXT_LIMIT   = 79
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [1:0]  d_method,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [7:0]  mem_word_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_save_method,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  localparam int unsigned CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [8:0]  DEPTH_W    = 9'(MEM_DEPTH);
  localparam logic [8:0]  TEXT_W     = 9'(TEXT_LIMIT);

`ifdef UMA_TEXT_PROT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  logic [1:0]    state_q, state_d;
  logic          win_d_q, win_d_d;
  logic [7:0]    addr_q, addr_d;
  logic          we_q, we_d;
  logic [1:0]    method_q, method_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          err_q, err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  logic        serving;
  logic        in_range;
  logic        prot_hit;
  logic        access_ok;
  logic        pick_d;
  logic [31:0] rd_word;

  assign serving   = (state_q == ST_SERVE_I) || (state_q == ST_SERVE_D);
  assign in_range  = {1'b0, addr_q} < DEPTH_W;
  assign prot_hit  = PROT_EN & we_q & ({1'b0, addr_q} < TEXT_W);
  assign access_ok = in_range & ~prot_hit;
  assign rd_word   = in_range ? mem_rdata : 32'h0;

  // Data wins ties unless fetch has already lost STARVE_LIMIT times in a row.
  assign pick_d = d_req & ~(if_req & (starve_q == STARVE_MAX));

  // NOTE: every always_comb output is assigned a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    win_d_d    = win_d_q;
    addr_d     = addr_q;
    we_d       = we_q;
    method_d   = method_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          state_d  = pick_d ? ST_SERVE_D : ST_SERVE_I;
          win_d_d  = pick_d;
          addr_d   = pick_d ? d_addr : if_addr;
          we_d     = pick_d & d_we;
          method_d = pick_d ? d_method : 2'b00;
          wdata_d  = pick_d ? d_wdata : 32'h0;
          err_d    = 1'b0;
          if (!pick_d) begin
            starve_d = '0;
          end else if (if_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + CW'(1);
          end
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        state_d = ST_ACK;
        err_d   = win_d_q & ~access_ok;
        if (win_d_q) d_rdata_d  = rd_word;
        else         if_rdata_d = rd_word;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_d_q    <= 1'b0;
      addr_q     <= 8'h0;
      we_q       <= 1'b0;
      method_q   <= 2'b00;
      wdata_q    <= 32'h0;
      starve_q   <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      win_d_q    <= win_d_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      method_q   <= method_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Memory controls come straight from state, so an async reset kills a pending write at once.
  assign mem_word_addr   = serving ? addr_q : 8'h0;
  assign mem_read        = serving & in_range & ~we_q;
  assign mem_write       = serving & access_ok & we_q;
  assign mem_save_method = serving ? method_q : 2'b00;
  assign mem_wdata       = (serving & we_q) ? wdata_q : 32'h0;

  assign if_ack   = (state_q == ST_ACK) & ~win_d_q;
  assign d_ack    = (state_q == ST_ACK) & win_d_q;
  assign d_err    = d_ack & err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios then randomized traffic
// against a transaction-level model of arbitration and memory contents.
module tb_unified_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int MEM_DEPTH    = 128;
  localparam int TEXT_LIMIT   = 79;
  localparam logic [1:0] SB = 2'd0;
  localparam logic [1:0] SH = 2'd1;
  localparam logic [1:0] SW = 2'd2;
`ifdef UMA_TEXT_PROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [7:0]  if_addr, d_addr;
  logic [1:0]  d_method;
  logic [31:0] d_wdata;
  logic        if_ack, d_ack, d_err, mem_read, mem_write, busy;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_word_addr;
  logic [1:0]  mem_save_method;
  logic        mem_init;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int checks = 0;
  int errors = 0;
  int ref_starve = 0;
  logic [31:0] exp_if_rd, exp_d_rd;
  bit d_rd_known;
  logic last_d_ack, last_d_err;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT), .MEM_DEPTH(MEM_DEPTH), .TEXT_LIMIT(TEXT_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_method(d_method), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_word_addr(mem_word_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_save_method(mem_save_method), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 1)  return 32'h00100093;
    if (i == 10) return 32'h0411e393;
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] m);
    case (m)
      SB:      return {old[31:8], wd[7:0]};
      SH:      return {old[31:16], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  // Behavioural memory: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      mem[mem_word_addr] <= merge(mem[mem_word_addr], mem_wdata, mem_save_method);
    end
  end
  assign mem_rdata = mem[mem_word_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 8'($urandom_range(MEM_DEPTH, 255));
    return 8'($urandom_range(0, MEM_DEPTH - 1));
  endfunction

  task automatic new_d_req();
    d_req    = 1'b1;
    d_we     = 1'($urandom_range(0, 1));
    d_addr   = rand_addr();
    d_method = 2'($urandom_range(0, 2));
    d_wdata  = $urandom;
  endtask

  // One complete access starting in IDLE just before the sampling edge.
  task automatic access(input bit hold, output bit win_d);
    logic [7:0]  a;
    bit          we, oor, prot;
    logic [31:0] rd;
    win_d = d_req && !(if_req && ref_starve == STARVE_LIMIT);
    if (!win_d) ref_starve = 0;
    else if (if_req && ref_starve < STARVE_LIMIT) ref_starve++;
    a    = win_d ? d_addr : if_addr;
    we   = win_d && d_we;
    oor  = (a >= MEM_DEPTH);
    prot = PROT_ON && we && (a < TEXT_LIMIT);
    rd   = oor ? 32'h0 : ref_mem[a];

    @(posedge clk); #1;
    check("serve_busy", busy, 1);
    check("serve_read", mem_read, !oor && !we);
    check("serve_write", mem_write, !oor && we && !prot);
    if (!oor) check("serve_addr", mem_word_addr, a);
    if (we && !oor && !prot) begin
      check("serve_wdata", mem_wdata, d_wdata);
      check("serve_method", mem_save_method, d_method);
    end

    @(posedge clk); #1;
    if (we && !oor && !prot) ref_mem[a] = merge(ref_mem[a], d_wdata, d_method);
    if (we) d_rd_known = 1'b0;
    else if (win_d) begin exp_d_rd = rd; d_rd_known = 1'b1; end
    else exp_if_rd = rd;
    last_d_ack = d_ack;
    last_d_err = d_err;
    check("ack_if", if_ack, !win_d);
    check("ack_d", d_ack, win_d);
    check("ack_err", d_err, win_d && (oor || prot));
    check("if_rdata", if_rdata, exp_if_rd);
    if (d_rd_known) check("d_rdata", d_rdata, exp_d_rd);
    check("ack_mem_idle", {mem_read, mem_write}, 2'b00);
    if (we && !oor) check("mem_word", mem[a], ref_mem[a]);
    if (!hold) begin
      if (win_d) d_req = 1'b0;
      else       if_req = 1'b0;
    end

    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_acks", {if_ack, d_ack}, 2'b00);
  endtask

  initial begin
    bit w;
    logic [11:0] seq;
    rst_n = 1'b0; mem_init = 1'b1;
    if_req = 1'b0; if_addr = 8'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h0; d_method = SB; d_wdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_if_rd = 32'h0; exp_d_rd = 32'h0; d_rd_known = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_acks", {if_ack, d_ack, d_err}, 3'b000);
    check("rst_mem_ctl", {mem_read, mem_write}, 2'b00);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch only
    if_addr = 8'd1; if_req = 1'b1;
    access(1'b0, w);
    check("fetch_winner", w, 0);
    check("fetch_word", if_rdata, 32'h00100093);

    // Store then load
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd100; d_method = SW; d_wdata = 32'hDEADBEEF;
    access(1'b0, w);
    check("store_err", last_d_err, 0);
    d_req = 1'b1; d_we = 1'b0;
    access(1'b0, w);
    check("load_100", d_rdata, 32'hDEADBEEF);
    check("fetch_hold", if_rdata, 32'h00100093);

    // Out-of-range load
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'd200;
    access(1'b0, w);
    check("oor_rdata", d_rdata, 32'h0);
    check("oor_err", last_d_err, 1);

    // Store into the text region, then read it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd10; d_method = SW; d_wdata = 32'h12345678;
    access(1'b0, w);
    check("text_store_err", last_d_err, PROT_ON);
    d_req = 1'b1; d_we = 1'b0;
    access(1'b0, w);
    check("text_word", d_rdata, PROT_ON ? 32'h0411e393 : 32'h12345678);

    // Contention: both requests held high continuously
    if_addr = 8'd5; d_addr = 8'd120; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      access(1'b1, w);
      seq[11 - k] = last_d_ack;
    end
    check("contention_order", seq, 12'b1111_0111_1011);
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    // Reset during a SERVE_D store
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd95; d_method = SW; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("rst_mid_write_pre", mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_write", mem_write, 0);
    check("rst_mid_busy", busy, 0);
    d_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_starve = 0; exp_if_rd = 32'h0; exp_d_rd = 32'h0; d_rd_known = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("rst_mid_no_ack", {d_ack, busy}, 2'b00);
      @(posedge clk); #1;
    end
    check("rst_mid_word95", mem[95], ref_mem[95]);
    check("rst_mid_d_rdata", d_rdata, 32'h0);

    // Randomized traffic; a losing requester keeps its request pending
    for (int n = 0; n < 60; n++) begin
      if (!if_req && !d_req) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
      if (!d_req && $urandom_range(0, 1) == 1) new_d_req();
      if (!if_req && !d_req) new_d_req();
      access(1'b0, w);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
